// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART link with a configurable bit period, 5..9 data bits and 1..2 stop bits; UART_PARITY_EN adds a parity bit.
// Latency: tx_o starts one cycle after the handshake; rx_valid follows about 2 + CLKS_PER_BIT/2 + (data+parity+1) bit periods after rx_i falls.
// Backpressure: tx_ready stays low for the whole frame and tx_valid is dropped meanwhile; RX has none, so a missed rx_valid loses the word.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 260,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2
        || PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParams
        $error("uart_transceiver: illegal parameter set");
    end

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rxState_t;

    txState_t             txState, txStateNxt;
    logic [CW-1:0]        txCnt, txCntNxt;
    logic [BW-1:0]        txBit, txBitNxt;
    logic [DATA_BITS-1:0] txShift, txShiftNxt;
    logic                 txOut, txOutNxt;
    logic                 txRdy, txRdyNxt;
`ifdef UART_PARITY_EN
    logic                 txPar, txParNxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
            txOut   <= 1'b1;
            txRdy   <= 1'b1;
`ifdef UART_PARITY_EN
            txPar   <= 1'b0;
`endif
        end else begin
            txState <= txStateNxt;
            txCnt   <= txCntNxt;
            txBit   <= txBitNxt;
            txShift <= txShiftNxt;
            txOut   <= txOutNxt;
            txRdy   <= txRdyNxt;
`ifdef UART_PARITY_EN
            txPar   <= txParNxt;
`endif
        end
    end

    always_comb begin
        txStateNxt = txState;
        txCntNxt   = txCnt + 1'b1;
        txBitNxt   = txBit;
        txShiftNxt = txShift;
        txOutNxt   = txOut;
        txRdyNxt   = txRdy;
`ifdef UART_PARITY_EN
        txParNxt   = txPar;
`endif
        case (txState)
            TX_IDLE: begin
                txCntNxt = '0;
                txOutNxt = 1'b1;
                if (tx_valid && txRdy) begin
                    txShiftNxt = tx_data;
                    txRdyNxt   = 1'b0;
                    txOutNxt   = 1'b0;
                    txStateNxt = TX_START;
`ifdef UART_PARITY_EN
                    txParNxt   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            TX_START: begin
                if (txCnt == BIT_LAST) begin
                    txCntNxt   = '0;
                    txBitNxt   = '0;
                    txOutNxt   = txShift[0];
                    txStateNxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (txCnt == BIT_LAST) begin
                    txCntNxt = '0;
                    if (txBit == DATA_LAST) begin
                        txBitNxt   = '0;
`ifdef UART_PARITY_EN
                        txOutNxt   = txPar;
                        txStateNxt = TX_PARITY;
`else
                        txOutNxt   = 1'b1;
                        txStateNxt = TX_STOP;
`endif
                    end else begin
                        // the bit being shifted out always sits in txShift[0]
                        txBitNxt   = txBit + 1'b1;
                        txShiftNxt = txShift >> 1;
                        txOutNxt   = txShift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (txCnt == BIT_LAST) begin
                    txCntNxt   = '0;
                    txOutNxt   = 1'b1;
                    txStateNxt = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (txCnt == BIT_LAST) begin
                    txCntNxt = '0;
                    if (txBit == STOP_LAST) begin
                        txRdyNxt   = 1'b1;
                        txStateNxt = TX_IDLE;
                    end else begin
                        txBitNxt = txBit + 1'b1;
                    end
                end
            end
            default: txStateNxt = TX_IDLE;
        endcase
    end

    assign tx_o     = txOut;
    assign tx_ready = txRdy;

    // rxSync[1] is the metastability-safe copy of rx_i
    logic [1:0] rxSync;
    logic       rxLine;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxSync <= 2'b11;
        end else begin
            rxSync <= {rxSync[0], rx_i};
        end
    end

    assign rxLine = rxSync[1];

    rxState_t             rxState, rxStateNxt;
    logic [CW-1:0]        rxCnt, rxCntNxt;
    logic [BW-1:0]        rxBit, rxBitNxt;
    logic [DATA_BITS-1:0] rxShift, rxShiftNxt;
    logic [DATA_BITS-1:0] rxDataQ, rxDataNxt;
    logic                 rxValidQ, rxValidNxt;
    logic                 rxFrameErrQ, rxFrameErrNxt;
`ifdef UART_PARITY_EN
    logic                 rxParBad, rxParBadNxt;
    logic                 rxParErrQ, rxParErrNxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxState     <= RX_IDLE;
            rxCnt       <= '0;
            rxBit       <= '0;
            rxShift     <= '0;
            rxDataQ     <= '0;
            rxValidQ    <= 1'b0;
            rxFrameErrQ <= 1'b0;
`ifdef UART_PARITY_EN
            rxParBad    <= 1'b0;
            rxParErrQ   <= 1'b0;
`endif
        end else begin
            rxState     <= rxStateNxt;
            rxCnt       <= rxCntNxt;
            rxBit       <= rxBitNxt;
            rxShift     <= rxShiftNxt;
            rxDataQ     <= rxDataNxt;
            rxValidQ    <= rxValidNxt;
            rxFrameErrQ <= rxFrameErrNxt;
`ifdef UART_PARITY_EN
            rxParBad    <= rxParBadNxt;
            rxParErrQ   <= rxParErrNxt;
`endif
        end
    end

    always_comb begin
        rxStateNxt    = rxState;
        rxCntNxt      = rxCnt + 1'b1;
        rxBitNxt      = rxBit;
        rxShiftNxt    = rxShift;
        rxDataNxt     = rxDataQ;
        rxValidNxt    = 1'b0;
        rxFrameErrNxt = 1'b0;
`ifdef UART_PARITY_EN
        rxParBadNxt   = rxParBad;
        rxParErrNxt   = 1'b0;
`endif
        case (rxState)
            RX_IDLE: begin
                rxCntNxt = '0;
                if (!rxLine) begin
                    rxStateNxt = RX_START;
                end
            end
            RX_START: begin
                // a start bit gone high again by mid-bit is treated as line noise
                if (rxCnt == HALF_LAST) begin
                    rxCntNxt   = '0;
                    rxBitNxt   = '0;
                    rxStateNxt = rxLine ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNxt   = '0;
                    rxShiftNxt = {rxLine, rxShift[DATA_BITS-1:1]};
                    if (rxBit == DATA_LAST) begin
                        rxBitNxt   = '0;
`ifdef UART_PARITY_EN
                        rxStateNxt = RX_PARITY;
`else
                        rxStateNxt = RX_STOP;
`endif
                    end else begin
                        rxBitNxt = rxBit + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNxt    = '0;
                    rxParBadNxt = rxLine ^ (^rxShift) ^ 1'(PARITY_ODD);
                    rxStateNxt  = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNxt      = '0;
                    rxValidNxt    = 1'b1;
                    rxDataNxt     = rxShift;
                    rxFrameErrNxt = !rxLine;
`ifdef UART_PARITY_EN
                    rxParErrNxt   = rxParBad;
`endif
                    rxStateNxt    = rxLine ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                rxCntNxt = '0;
                if (rxLine) begin
                    rxStateNxt = RX_IDLE;
                end
            end
            default: rxStateNxt = RX_IDLE;
        endcase
    end

    assign rx_data      = rxDataQ;
    assign rx_valid     = rxValidQ;
    assign rx_frame_err = rxFrameErrQ;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rxParErrQ;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
